string_matcher_param: RTL and testbench

- Parametrised serial string matcher. Compares two serial bit streams `a` and `b` over a programmable length LEN.
- Counts per-bit mismatches (Hamming distance) and reports pass/fail against a runtime mismatch threshold.
- Optional early abort ends the run as soon as the result is decided as a fail.
- Generalises the fixed 4-bit exact-match controller/datapath pair. Sits at top level of the string-matching subsystem, driven by the same serial `a`/`b` sources.

---
 rtl/string_matcher_param.sv | 95 +++++++++
 tb/tb_string_matcher_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/string_matcher_param.sv
// Serial string matcher: counts bit mismatches between streams a and b over LEN
// samples and flags a match when the count stays within a threshold latched at start.
module string_matcher_param #(
    parameter int unsigned LEN         = 4,
    parameter int unsigned CW          = $clog2(LEN + 1),
    parameter bit          EARLY_ABORT = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          a,
    input  logic          b,
    input  logic [CW-1:0] thresh,
    output logic          busy,
    output logic          done,
    output logic          y_val,
    output logic [CW-1:0] mism_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] mism_q, mism_d;
    logic [CW-1:0] thr_q, thr_d;
    logic          y_q, y_d;

    logic          mis;
    logic [CW-1:0] next_cnt;
    logic          last_bit;

    assign mis      = a ^ b;
    assign next_cnt = mism_q + CW'(mis);
    assign last_bit = (bit_cnt_q == CW'(LEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            mism_q    <= '0;
            thr_q     <= '0;
            y_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            mism_q    <= mism_d;
            thr_q     <= thr_d;
            y_q       <= y_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        mism_d    = mism_q;
        thr_d     = thr_q;
        y_d       = y_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts start directly so back-to-back runs have no idle gap
                if (start) begin
                    state_d   = S_RUN;
                    bit_cnt_d = '0;
                    mism_d    = '0;
                    thr_d     = thresh;
                    y_d       = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                bit_cnt_d = bit_cnt_q + CW'(1);
                mism_d    = next_cnt;
                if (EARLY_ABORT && (next_cnt > thr_q)) begin
                    state_d = S_DONE;
                    y_d     = 1'b0;
                end else if (last_bit) begin
                    state_d = S_DONE;
                    y_d     = (next_cnt <= thr_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign y_val    = y_q;
    assign mism_cnt = mism_q;

endmodule

// File: tb/tb_string_matcher_param.sv
// Directed bench for string_matcher_param: LEN=4 without and with early abort
// sharing one stimulus, plus a LEN=16 instance for the threshold sweep.
module tb_string_matcher_param;

    logic       clk;
    logic       reset;
    logic       start, a, b;
    logic [2:0] thresh;
    logic       start16, a16, b16;
    logic [4:0] thresh16;

    logic       busy4, done4, y4;
    logic [2:0] mism4;
    logic       busy4e, done4e, y4e;
    logic [2:0] mism4e;
    logic       busy16, done16, y16;
    logic [4:0] mism16;

    int checks;
    int failures;
    int done_e4, done_e4e, done_e16;
    int busy_n4, busy_n4e;

    string_matcher_param #(.LEN(4), .EARLY_ABORT(1'b0)) dut4 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .thresh(thresh),
        .busy(busy4), .done(done4), .y_val(y4), .mism_cnt(mism4)
    );

    string_matcher_param #(.LEN(4), .EARLY_ABORT(1'b1)) dut4e (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .thresh(thresh),
        .busy(busy4e), .done(done4e), .y_val(y4e), .mism_cnt(mism4e)
    );

    string_matcher_param #(.LEN(16), .EARLY_ABORT(1'b0)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .thresh(thresh16),
        .busy(busy16), .done(done16), .y_val(y16), .mism_cnt(mism16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample4(input int n);
        if (busy4)  busy_n4++;
        if (busy4e) busy_n4e++;
        if (done4  && done_e4  == 0) done_e4  = n;
        if (done4e && done_e4e == 0) done_e4e = n;
    endtask

    // Start edge is edge 0; bits MSB first on edges 1..4. Returns just after edge 4.
    // thresh is inverted during the run so any use of the live value shows up.
    task automatic run4(input logic [3:0] va, input logic [3:0] vb, input logic [2:0] th);
        done_e4 = 0; done_e4e = 0; busy_n4 = 0; busy_n4e = 0;
        start = 1'b1; thresh = th;
        step();
        start = 1'b0; thresh = ~th;
        sample4(0);
        for (int i = 0; i < 4; i++) begin
            a = va[3-i]; b = vb[3-i];
            step();
            sample4(i + 1);
        end
        a = 1'b0; b = 1'b0;
    endtask

    task automatic run16(input logic [15:0] va, input logic [15:0] vb, input logic [4:0] th);
        done_e16 = 0;
        start16 = 1'b1; thresh16 = th;
        step();
        start16 = 1'b0; thresh16 = 5'd0;
        for (int i = 0; i < 16; i++) begin
            a16 = va[15-i]; b16 = vb[15-i];
            step();
            if (done16 && done_e16 == 0) done_e16 = i + 1;
        end
        a16 = 1'b0; b16 = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0;
        start = 1'b0; a = 1'b0; b = 1'b0; thresh = '0;
        start16 = 1'b0; a16 = 1'b0; b16 = 1'b0; thresh16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_y4", y4, 0);
        chk("rst_mism4", mism4, 0);
        chk("rst_busy16", busy16, 0);
        chk("rst_mism16", mism16, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Exact match
        run4(4'b1011, 4'b1011, 3'd0);
        chk("exact_busy_cycles", busy_n4, 4);
        chk("exact_done_edge", done_e4, 4);
        chk("exact_y", y4, 1);
        chk("exact_mism", mism4, 0);
        chk("exact_ea_y", y4e, 1);
        step();
        chk("exact_done_drop", done4, 0);
        chk("exact_y_held", y4, 1);
        step();

        // Threshold boundary
        run4(4'b1011, 4'b1001, 3'd1);
        chk("thr1_y", y4, 1);
        chk("thr1_mism", mism4, 1);
        chk("thr1_ea_y", y4e, 1);
        step();
        run4(4'b1011, 4'b1001, 3'd0);
        chk("thr0_done_edge", done_e4, 4);
        chk("thr0_y", y4, 0);
        chk("thr0_mism", mism4, 1);
        chk("thr0_ea_done_edge", done_e4e, 3);
        chk("thr0_ea_y", y4e, 0);
        step();

        // Early abort versus full run
        run4(4'b0000, 4'b1111, 3'd1);
        chk("abort_done_edge", done_e4e, 2);
        chk("abort_busy_cycles", busy_n4e, 2);
        chk("abort_mism", mism4e, 2);
        chk("abort_y", y4e, 0);
        chk("noabort_done_edge", done_e4, 4);
        chk("noabort_mism", mism4, 4);
        chk("noabort_y", y4, 0);
        step();

        // thresh >= LEN: always matches, abort impossible
        run4(4'b0000, 4'b1111, 3'd4);
        chk("thrlen_ea_done_edge", done_e4e, 4);
        chk("thrlen_ea_y", y4e, 1);
        chk("thrlen_ea_mism", mism4e, 4);
        step();

        // start held high through the run, then back-to-back from DONE
        start = 1'b1; thresh = 3'd3;
        step();
        for (int i = 0; i < 4; i++) begin
            a = 1'b1; b = 1'b0;
            step();
            if (i == 1) chk("held_mid_mism", mism4, 2);
        end
        chk("held_done", done4, 1);
        chk("held_mism", mism4, 4);
        chk("held_y", y4, 0);
        thresh = 3'd0;
        step();
        start = 1'b0; thresh = 3'd7;
        chk("b2b_busy", busy4, 1);
        chk("b2b_done_low", done4, 0);
        chk("b2b_mism_clear", mism4, 0);
        for (int i = 0; i < 4; i++) begin
            a = (i == 0 || i == 2); b = (i == 0);
            step();
            if (i == 2) chk("b2b_no_early_done", done4, 0);
        end
        chk("b2b_second_done", done4, 1);
        chk("b2b_mism", mism4, 1);
        chk("b2b_y", y4, 0);
        a = 1'b0; b = 1'b0;
        step();

        // Asynchronous reset mid-run
        start = 1'b1; thresh = 3'd3;
        step();
        start = 1'b0;
        a = 1'b0; b = 1'b1;
        step();
        step();
        chk("prereset_busy", busy4, 1);
        chk("prereset_mism", mism4, 2);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", busy4, 0);
        chk("arst_done", done4, 0);
        chk("arst_y", y4, 0);
        chk("arst_mism", mism4, 0);
        a = 1'b0; b = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        run4(4'b0110, 4'b0110, 3'd0);
        chk("postrst_done_edge", done_e4, 4);
        chk("postrst_y", y4, 1);
        chk("postrst_mism", mism4, 0);
        step();

        // LEN=16 sweep, thresh=3
        run16(16'hA5C3, 16'hA5C3 ^ 16'h0111, 5'd3);
        chk("len16_3_done_edge", done_e16, 16);
        chk("len16_3_y", y16, 1);
        chk("len16_3_mism", mism16, 3);
        step();
        run16(16'hA5C3, 16'hA5C3 ^ 16'h8111, 5'd3);
        chk("len16_4_done_edge", done_e16, 16);
        chk("len16_4_y", y16, 0);
        chk("len16_4_mism", mism16, 4);
        step();
        chk("len16_y_held", y16, 0);
        chk("len16_mism_held", mism16, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
